// File: rtl/usb_fs_rx_txn_ctrl_if.sv
// usb_fs_rx_txn_ctrl_if: receiver, endpoint-buffer and handshake signals of usb_fs_rx_txn_ctrl
interface usb_fs_rx_txn_ctrl_if #(parameter int NUM_EP = 4);
   logic [6:0] dev_addr;
   logic pkt_start;
   logic pkt_end;
   logic [3:0] pid;
   logic [6:0] addr;
   logic [3:0] endp;
   logic valid_packet;
   logic rx_data_put;
   logic [7:0] rx_data;
   logic [NUM_EP-1:0] ep_ready;
   logic [NUM_EP-1:0] ep_stall_set;
   logic [NUM_EP-1:0] ep_toggle_clr;
   logic hs_ack;
   logic [3:0] ep_sel;
   logic ep_put;
   logic [7:0] ep_data;
   logic ep_commit;
   logic ep_rollback;
   logic setup_rx;
   logic hs_req;
   logic [3:0] hs_pid;
   logic [NUM_EP-1:0] stall_q;
   logic [15:0] err_count;
   logic [15:0] timeout_count;
   modport slave (
      input dev_addr, pkt_start, pkt_end, pid, addr, endp, valid_packet, rx_data_put, rx_data,
            ep_ready, ep_stall_set, ep_toggle_clr, hs_ack,
      output ep_sel, ep_put, ep_data, ep_commit, ep_rollback, setup_rx, hs_req, hs_pid,
             stall_q, err_count, timeout_count
   );
   modport master (
      output dev_addr, pkt_start, pkt_end, pid, addr, endp, valid_packet, rx_data_put, rx_data,
             ep_ready, ep_stall_set, ep_toggle_clr, hs_ack,
      input ep_sel, ep_put, ep_data, ep_commit, ep_rollback, setup_rx, hs_req, hs_pid,
            stall_q, err_count, timeout_count
   );
endinterface

// File: rtl/usb_fs_rx_txn_ctrl.sv
// usb_fs_rx_txn_ctrl: full-speed OUT/SETUP sequencer (token -> data -> handshake) with per-endpoint toggle/stall
// Define USB_RX_TXN_STATS_EN to implement err_count/timeout_count; otherwise both read 0.
module usb_fs_rx_txn_ctrl #(
   parameter int NUM_EP = 4,
   parameter int MAX_PKT_BYTES = 64,
   parameter int TIMEOUT_CLKS = 72
) (
   input logic clk_48mhz,
   input logic reset,
   usb_fs_rx_txn_ctrl_if.slave bus
);
   localparam logic [3:0] PID_OUT = 4'b0001, PID_SETUP = 4'b1101, PID_DATA0 = 4'b0011, PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK = 4'b0010, PID_NAK = 4'b1010, PID_STALL = 4'b1110;
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam int BW = $clog2(MAX_PKT_BYTES + 2);
   typedef enum logic [1:0] {IDLE, WAIT_DATA, RX_DATA, HANDSHAKE} state_t;
   state_t state, state_n;
   logic [3:0] ep_sel_q, ep_sel_n, hs_pid_q, hs_pid_n;
   logic is_setup, is_setup_n;
   logic [TW-1:0] to_cnt, to_cnt_n;
   logic [BW-1:0] byte_cnt, byte_cnt_n;
   logic commit_q, commit_n, rollback_q, rollback_n, setup_rx_q, setup_rx_n;
   logic [NUM_EP-1:0] tog, stall, flip, load, ep_mask;
   logic tok_ok, bad, stall_cur, ready_cur, tog_match, accept, err_inc, to_inc;
   assign ep_mask = NUM_EP'(1) << ep_sel_q;
   assign stall_cur = |(stall & ep_mask);
   assign ready_cur = |(bus.ep_ready & ep_mask);
   assign tog_match = bus.pid[3] == |(tog & ep_mask);
   assign tok_ok = bus.pkt_end && bus.valid_packet && (bus.pid == PID_OUT || bus.pid == PID_SETUP) &&
                   bus.addr == bus.dev_addr && {28'd0, bus.endp} < NUM_EP;
   assign bad = !bus.valid_packet || !(bus.pid == PID_DATA0 || bus.pid == PID_DATA1) ||
                byte_cnt > BW'(MAX_PKT_BYTES) || (is_setup && bus.pid != PID_DATA0);
   // SETUP always commits; a data packet commits only when it carries new (expected-toggle) data
   assign accept = is_setup || (!stall_cur && ready_cur && tog_match);
   always_comb begin
      state_n = state;
      ep_sel_n = ep_sel_q;
      is_setup_n = is_setup;
      to_cnt_n = to_cnt;
      byte_cnt_n = byte_cnt;
      hs_pid_n = hs_pid_q;
      commit_n = 1'b0;
      rollback_n = 1'b0;
      setup_rx_n = 1'b0;
      flip = '0;
      load = '0;
      err_inc = 1'b0;
      to_inc = 1'b0;
      case (state)
         IDLE: if (tok_ok) begin
            state_n = WAIT_DATA;
            ep_sel_n = bus.endp;
            is_setup_n = bus.pid == PID_SETUP;
            to_cnt_n = '0;
            byte_cnt_n = '0;
         end
         WAIT_DATA: begin
            to_cnt_n = to_cnt + 1'b1;
            if (bus.pkt_start) state_n = RX_DATA;
            else if (to_cnt == TW'(TIMEOUT_CLKS - 1)) begin
               state_n = IDLE;
               to_inc = 1'b1;
            end
         end
         RX_DATA: begin
            if (bus.rx_data_put && byte_cnt <= BW'(MAX_PKT_BYTES)) byte_cnt_n = byte_cnt + 1'b1;
            if (bus.pkt_end && bad) begin
               state_n = IDLE;
               rollback_n = 1'b1;
               err_inc = 1'b1;
            end else if (bus.pkt_end) begin
               state_n = HANDSHAKE;
               hs_pid_n = is_setup ? PID_ACK : stall_cur ? PID_STALL : !ready_cur ? PID_NAK : PID_ACK;
               commit_n = accept;
               rollback_n = !accept;
               setup_rx_n = is_setup;
               load = is_setup ? ep_mask : '0;
               flip = (!is_setup && accept) ? ep_mask : '0;
            end
         end
         HANDSHAKE: if (bus.hs_ack) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state <= IDLE;
         ep_sel_q <= '0;
         is_setup <= 1'b0;
         to_cnt <= '0;
         byte_cnt <= '0;
         hs_pid_q <= '0;
         commit_q <= 1'b0;
         rollback_q <= 1'b0;
         setup_rx_q <= 1'b0;
         tog <= '0;
         stall <= '0;
      end else begin
         state <= state_n;
         ep_sel_q <= ep_sel_n;
         is_setup <= is_setup_n;
         to_cnt <= to_cnt_n;
         byte_cnt <= byte_cnt_n;
         hs_pid_q <= hs_pid_n;
         commit_q <= commit_n;
         rollback_q <= rollback_n;
         setup_rx_q <= setup_rx_n;
         tog <= ((tog ^ flip) | load) & ~bus.ep_toggle_clr;
         stall <= (stall & ~load) | bus.ep_stall_set;
      end
   end
   assign bus.ep_sel = ep_sel_q;
   assign bus.ep_put = state == RX_DATA && bus.rx_data_put;
   assign bus.ep_data = state == RX_DATA ? bus.rx_data : '0;
   assign bus.ep_commit = commit_q;
   assign bus.ep_rollback = rollback_q;
   assign bus.setup_rx = setup_rx_q;
   assign bus.hs_req = state == HANDSHAKE;
   assign bus.hs_pid = hs_pid_q;
   assign bus.stall_q = stall;
`ifdef USB_RX_TXN_STATS_EN
   logic [15:0] err_q, to_q;
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         err_q <= '0;
         to_q <= '0;
      end else begin
         if (err_inc && ~&err_q) err_q <= err_q + 1'b1;
         if (to_inc && ~&to_q) to_q <= to_q + 1'b1;
      end
   end
   assign bus.err_count = err_q;
   assign bus.timeout_count = to_q;
`else
   logic unused_stats;
   assign unused_stats = err_inc ^ to_inc;
   assign bus.err_count = '0;
   assign bus.timeout_count = '0;
`endif
endmodule

// File: tb/tb_usb_fs_rx_txn_ctrl.sv
// tb_usb_fs_rx_txn_ctrl: scoreboard bench for usb_fs_rx_txn_ctrl; expected transactions queued by stimulus, checked by a monitor
`timescale 1ns/1ps
module tb_usb_fs_rx_txn_ctrl;
   localparam int NUM_EP = 4;
`ifdef USB_RX_TXN_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif
   localparam logic [3:0] OUT = 4'h1, SETUP = 4'hD, IN = 4'h9, SOF = 4'h5, D0 = 4'h3, D1 = 4'hB;
   localparam logic [3:0] ACK = 4'h2, NAK = 4'hA, STL = 4'hE;
   localparam logic [6:0] ME = 7'd5;
   typedef struct packed {logic c; logic r; logic s; logic q; logic [3:0] hp; logic [3:0] ep; logic [7:0] n;} exp_t;
   logic clk_48mhz = 1'b0;
   logic reset = 1'b1;
   usb_fs_rx_txn_ctrl_if #(.NUM_EP(NUM_EP)) bus();
   usb_fs_rx_txn_ctrl #(.NUM_EP(NUM_EP), .MAX_PKT_BYTES(64), .TIMEOUT_CLKS(72)) dut (
      .clk_48mhz(clk_48mhz),
      .reset(reset),
      .bus(bus)
   );
   always #10 clk_48mhz = ~clk_48mhz;
   exp_t sb[$];
   exp_t e, a;
   int checks = 0;
   int errors = 0;
   int put_cnt = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk_48mhz);
      #1;
   endtask
   task automatic token(input logic [3:0] p, input logic [6:0] ad, input logic [3:0] ep, input logic v);
      bus.pkt_start = 1'b1;
      tick();
      bus.pkt_start = 1'b0;
      tick();
      tick();
      bus.pkt_end = 1'b1;
      bus.pid = p;
      bus.addr = ad;
      bus.endp = ep;
      bus.valid_packet = v;
      tick();
      bus.pkt_end = 1'b0;
      bus.pid = 4'h0;
      bus.valid_packet = 1'b0;
   endtask
   task automatic data(input logic [3:0] p, input int n, input int gap);
      repeat (gap) tick();
      bus.pkt_start = 1'b1;
      tick();
      bus.pkt_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.rx_data_put = 1'b1;
         bus.rx_data = 8'(i) ^ 8'h5A;
         tick();
      end
      bus.rx_data_put = 1'b0;
      tick();
      bus.pkt_end = 1'b1;
      bus.pid = p;
      bus.valid_packet = 1'b1;
      tick();
      bus.pkt_end = 1'b0;
      bus.pid = 4'h0;
      bus.valid_packet = 1'b0;
   endtask
   task automatic expect_txn(input logic c, input logic r, input logic s, input logic q, input logic [3:0] hp,
                             input logic [3:0] ep, input int n);
      sb.push_back({c, r, s, q, hp, ep, 8'(n)});
   endtask
   task automatic hshake(input int hold);
      int w = 0;
      while (!bus.hs_req && w < 20) begin
         tick();
         w++;
      end
      chk("hs_req_rise", 32'(bus.hs_req), 32'd1);
      repeat (hold) tick();
      chk("hs_req_hold", 32'(bus.hs_req), 32'd1);
      bus.hs_ack = 1'b1;
      tick();
      bus.hs_ack = 1'b0;
      chk("hs_req_drop", 32'(bus.hs_req), 32'd0);
   endtask
   task automatic pulse_stall(input logic [NUM_EP-1:0] m);
      bus.ep_stall_set = m;
      tick();
      bus.ep_stall_set = '0;
   endtask
   initial begin
      bus.dev_addr = ME;
      bus.pkt_start = 1'b0;
      bus.pkt_end = 1'b0;
      bus.pid = 4'h0;
      bus.addr = 7'd0;
      bus.endp = 4'd0;
      bus.valid_packet = 1'b0;
      bus.rx_data_put = 1'b0;
      bus.rx_data = 8'h00;
      bus.ep_ready = 4'hF;
      bus.ep_stall_set = '0;
      bus.ep_toggle_clr = '0;
      bus.hs_ack = 1'b0;
      fork
         forever begin
            @(negedge clk_48mhz);
            if (reset) put_cnt = 0;
            else begin
               if (bus.ep_put) begin
                  chk("ep_data", 32'(bus.ep_data), 32'(8'(put_cnt) ^ 8'h5A));
                  put_cnt++;
               end
               if (bus.ep_commit || bus.ep_rollback) begin
                  if (sb.size() == 0) chk("unexpected_txn", {30'd0, bus.ep_commit, bus.ep_rollback}, 32'd0);
                  else begin
                     e = sb.pop_front();
                     a = {bus.ep_commit, bus.ep_rollback, bus.setup_rx, bus.hs_req, e.q ? bus.hs_pid : e.hp,
                          bus.ep_sel, 8'(put_cnt)};
                     chk("txn", 32'(a), 32'(e));
                  end
                  put_cnt = 0;
               end
            end
         end
      join_none
      repeat (3) tick();
      chk("rst_outs", {6'd0, bus.ep_sel, bus.ep_put, bus.ep_data, bus.ep_commit, bus.ep_rollback, bus.setup_rx,
                       bus.hs_req, bus.hs_pid, bus.stall_q}, 32'd0);
      chk("rst_counters", {bus.err_count, bus.timeout_count}, 32'd0);
      reset = 1'b0;
      tick();
      // new data, then retransmission, then next toggle on ep1
      expect_txn(1, 0, 0, 1, ACK, 4'd1, 10);
      token(OUT, ME, 4'd1, 1'b1);
      data(D0, 10, 0);
      hshake(0);
      expect_txn(0, 1, 0, 1, ACK, 4'd1, 10);
      token(OUT, ME, 4'd1, 1'b1);
      data(D0, 10, 0);
      hshake(2);
      expect_txn(1, 0, 0, 1, ACK, 4'd1, 4);
      token(OUT, ME, 4'd1, 1'b1);
      data(D1, 4, 0);
      hshake(0);
      // SETUP clears stall and loads DATA1 as expected toggle
      pulse_stall(4'b0001);
      chk("stall_set", 32'(bus.stall_q), 32'd1);
      expect_txn(1, 0, 1, 1, ACK, 4'd0, 8);
      token(SETUP, ME, 4'd0, 1'b1);
      data(D0, 8, 0);
      hshake(0);
      chk("setup_clears_stall", 32'(bus.stall_q), 32'd0);
      expect_txn(1, 0, 0, 1, ACK, 4'd0, 2);
      token(OUT, ME, 4'd0, 1'b1);
      data(D1, 2, 0);
      hshake(0);
      expect_txn(0, 1, 0, 0, 4'h0, 4'd0, 8);
      token(SETUP, ME, 4'd0, 1'b1);
      data(D1, 8, 0);
      repeat (3) tick();
      chk("setup_d1_no_hs", 32'(bus.hs_req), 32'd0);
      chk("err_count_1", 32'(bus.err_count), 32'(STATS));
      // NAK, then STALL taking priority over not-ready
      bus.ep_ready = 4'b1011;
      expect_txn(0, 1, 0, 1, NAK, 4'd2, 3);
      token(OUT, ME, 4'd2, 1'b1);
      data(D0, 3, 0);
      hshake(0);
      pulse_stall(4'b0100);
      expect_txn(0, 1, 0, 1, STL, 4'd2, 3);
      token(OUT, ME, 4'd2, 1'b1);
      data(D0, 3, 0);
      hshake(5);
      chk("stall_q_ep2", 32'(bus.stall_q), 32'h4);
      bus.ep_ready = 4'hF;
      // timeout, late data ignored, then data at the edge of the window
      token(OUT, ME, 4'd3, 1'b1);
      repeat (80) tick();
      chk("timeout_count", 32'(bus.timeout_count), 32'(STATS));
      chk("timeout_no_hs", 32'(bus.hs_req), 32'd0);
      data(D0, 4, 0);
      chk("late_data_puts", 32'(put_cnt), 32'd0);
      expect_txn(1, 0, 0, 1, ACK, 4'd3, 4);
      token(OUT, ME, 4'd3, 1'b1);
      data(D0, 4, 70);
      hshake(0);
      chk("timeout_count_keep", 32'(bus.timeout_count), 32'(STATS));
      // tokens that must be ignored
      token(OUT, 7'd6, 4'd1, 1'b1);
      data(D0, 2, 0);
      token(OUT, ME, 4'd7, 1'b1);
      data(D0, 2, 0);
      token(OUT, ME, 4'd1, 1'b0);
      data(D0, 2, 0);
      token(IN, ME, 4'd1, 1'b1);
      data(D0, 2, 0);
      token(SOF, ME, 4'd1, 1'b1);
      data(D0, 2, 0);
      chk("ignored_puts", 32'(put_cnt), 32'd0);
      chk("ignored_no_hs", 32'(bus.hs_req), 32'd0);
      // oversize vs. maximum-size packet on ep1 (expected toggle DATA0)
      expect_txn(0, 1, 0, 0, 4'h0, 4'd1, 66);
      token(OUT, ME, 4'd1, 1'b1);
      data(D0, 66, 0);
      repeat (2) tick();
      chk("err_count_2", 32'(bus.err_count), 32'(2 * STATS));
      expect_txn(1, 0, 0, 1, ACK, 4'd1, 64);
      token(OUT, ME, 4'd1, 1'b1);
      data(D0, 64, 0);
      hshake(0);
      // reset in the middle of a data packet
      token(OUT, ME, 4'd2, 1'b1);
      bus.pkt_start = 1'b1;
      tick();
      bus.pkt_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.rx_data_put = 1'b1;
         bus.rx_data = 8'(i) ^ 8'h5A;
         tick();
      end
      reset = 1'b1;
      tick();
      chk("midrst_outs", {6'd0, bus.ep_sel, bus.ep_put, bus.ep_data, bus.ep_commit, bus.ep_rollback, bus.setup_rx,
                          bus.hs_req, bus.hs_pid, bus.stall_q}, 32'd0);
      chk("midrst_counters", {bus.err_count, bus.timeout_count}, 32'd0);
      bus.rx_data_put = 1'b0;
      reset = 1'b0;
      tick();
      expect_txn(1, 0, 0, 1, ACK, 4'd1, 2);
      token(OUT, ME, 4'd1, 1'b1);
      data(D0, 2, 0);
      hshake(0);
      expect_txn(1, 0, 0, 1, ACK, 4'd2, 2);
      token(OUT, ME, 4'd2, 1'b1);
      data(D0, 2, 0);
      hshake(0);
      // explicit toggle clear on ep1 makes DATA0 new again
      bus.ep_toggle_clr = 4'b0010;
      tick();
      bus.ep_toggle_clr = '0;
      expect_txn(1, 0, 0, 1, ACK, 4'd1, 3);
      token(OUT, ME, 4'd1, 1'b1);
      data(D0, 3, 0);
      hshake(0);
      repeat (5) tick();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
